// File: rtl/sa_waddr_arbiter.sv
// Per-slave write-address arbiter: round-robin AW grant plus an order FIFO that steers the slave W channel.
// Define SA_WADDR_FIXED_PRIORITY_EN for lowest-index-wins arbitration (no round-robin pointer).
module sa_waddr_arbiter #(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int MST_ID_W          = $clog2(MST_AMT),
    parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESET_i,
    input  logic [MST_AMT*TRANS_MST_ID_W-1:0]      m_AWID_i,
    input  logic [MST_AMT*ADDR_WIDTH-1:0]          m_AWADDR_i,
    input  logic [MST_AMT*TRANS_BURST_W-1:0]       m_AWBURST_i,
    input  logic [MST_AMT*TRANS_DATA_LEN_W-1:0]    m_AWLEN_i,
    input  logic [MST_AMT*TRANS_DATA_SIZE_W-1:0]   m_AWSIZE_i,
    input  logic [MST_AMT-1:0]                     m_AWVALID_i,
    input  logic [MST_AMT-1:0]                     m_AW_outst_full_i,
    output logic [MST_AMT-1:0]                     m_AWREADY_o,
    output logic [TRANS_SLV_ID_W-1:0]              s_AWID_o,
    output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
    output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
    output logic                                   s_AWVALID_o,
    input  logic                                   s_AWREADY_i,
    input  logic                                   s_WVALID_i,
    input  logic                                   s_WREADY_i,
    output logic [MST_ID_W-1:0]                    dsp_WDATA_mst_id_o,
    output logic                                   dsp_WDATA_disable_o
);

    localparam int PTR_W   = $clog2(OUTSTANDING_AMT);
    localparam int CNT_W   = $clog2(OUTSTANDING_AMT + 1);
    localparam int ENTRY_W = MST_ID_W + TRANS_DATA_LEN_W;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t                      state_q, state_d;
    logic [MST_ID_W-1:0]         grant_q, grant_d;
    logic [MST_ID_W-1:0]         rr_start;
    logic [MST_AMT-1:0]          req;
    logic                        found;
    logic [MST_ID_W-1:0]         sel_idx;
    logic                        aw_hs;
    logic [TRANS_MST_ID_W-1:0]   awid_mux;

    logic [ENTRY_W-1:0]          fifo_mem [OUTSTANDING_AMT];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic                        fifo_empty, fifo_full;
    logic                        push, pop, w_hs;
    logic [TRANS_DATA_LEN_W-1:0] beat_q;
    logic [TRANS_DATA_LEN_W-1:0] head_len;
    logic [MST_ID_W-1:0]         head_mst;

    assign req = m_AWVALID_i & ~m_AW_outst_full_i;

`ifdef SA_WADDR_FIXED_PRIORITY_EN
    assign rr_start = '0;
`else
    logic [MST_ID_W-1:0] rr_ptr_q;

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            rr_ptr_q <= '0;
        end else if (aw_hs) begin
            rr_ptr_q <= (grant_q == MST_ID_W'(MST_AMT - 1)) ? '0 : grant_q + MST_ID_W'(1);
        end
    end

    assign rr_start = rr_ptr_q;
`endif

    // Circular search as two linear passes: [rr_start, MST_AMT) first, then wrap to [0, MST_AMT).
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < MST_AMT; i++) begin
            if (!found && req[i] && (MST_ID_W'(i) >= rr_start)) begin
                found   = 1'b1;
                sel_idx = MST_ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < MST_AMT; i++) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                sel_idx = MST_ID_W'(i);
            end
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        s_AWVALID_o = 1'b0;
        m_AWREADY_o = '0;
        aw_hs       = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && !fifo_full) begin
                    grant_d = sel_idx;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                s_AWVALID_o = m_AWVALID_i[grant_q];
                m_AWREADY_o = MST_AMT'(s_AWREADY_i) << grant_q;
                aw_hs       = s_AWVALID_o & s_AWREADY_i;
                if (aw_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        awid_mux    = '0;
        s_AWADDR_o  = '0;
        s_AWBURST_o = '0;
        s_AWLEN_o   = '0;
        s_AWSIZE_o  = '0;
        for (int unsigned i = 0; i < MST_AMT; i++) begin
            if (grant_q == MST_ID_W'(i)) begin
                awid_mux    = m_AWID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                s_AWADDR_o  = m_AWADDR_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_AWBURST_o = m_AWBURST_i[i*TRANS_BURST_W +: TRANS_BURST_W];
                s_AWLEN_o   = m_AWLEN_i[i*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
                s_AWSIZE_o  = m_AWSIZE_i[i*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
            end
        end
    end

    assign s_AWID_o = {grant_q, awid_mux};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(OUTSTANDING_AMT));
    assign head_len   = fifo_mem[rd_ptr_q][TRANS_DATA_LEN_W-1:0];
    assign head_mst   = fifo_empty ? '0 : fifo_mem[rd_ptr_q][ENTRY_W-1:TRANS_DATA_LEN_W];
    assign w_hs       = s_WVALID_i & s_WREADY_i & ~fifo_empty;
    assign push       = aw_hs;
    assign pop        = w_hs & (beat_q == head_len);

    always_ff @(posedge ACLK_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {grant_q, s_AWLEN_o};
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (w_hs) begin
                beat_q <= pop ? '0 : beat_q + TRANS_DATA_LEN_W'(1);
            end
        end
    end

    assign dsp_WDATA_mst_id_o  = head_mst;
    assign dsp_WDATA_disable_o = fifo_empty;

endmodule

// File: tb/tb_sa_waddr_arbiter.sv
// Directed bench for sa_waddr_arbiter (2 masters, 2-deep order FIFO): vector table plus multi-cycle sequences.
module tb_sa_waddr_arbiter;

    localparam int MST_AMT = 2;
    localparam int AW      = 32;
    localparam int IDW     = 5;
    localparam int LW      = 3;

    logic                     clk;
    logic                     rst;
    logic [MST_AMT*IDW-1:0]   m_awid;
    logic [MST_AMT*AW-1:0]    m_awaddr;
    logic [MST_AMT*2-1:0]     m_awburst;
    logic [MST_AMT*LW-1:0]    m_awlen;
    logic [MST_AMT*3-1:0]     m_awsize;
    logic [MST_AMT-1:0]       m_awvalid;
    logic [MST_AMT-1:0]       m_full;
    logic [MST_AMT-1:0]       m_awready;
    logic [IDW:0]             s_awid;
    logic [AW-1:0]            s_awaddr;
    logic [1:0]               s_awburst;
    logic [LW-1:0]            s_awlen;
    logic [2:0]               s_awsize;
    logic                     s_awvalid;
    logic                     s_awready;
    logic                     s_wvalid;
    logic                     s_wready;
    logic                     w_mst;
    logic                     w_dis;

    int n_checks = 0;
    int n_pass   = 0;

    sa_waddr_arbiter #(
        .MST_AMT(MST_AMT),
        .OUTSTANDING_AMT(2)
    ) dut (
        .ACLK_i(clk),
        .ARESET_i(rst),
        .m_AWID_i(m_awid),
        .m_AWADDR_i(m_awaddr),
        .m_AWBURST_i(m_awburst),
        .m_AWLEN_i(m_awlen),
        .m_AWSIZE_i(m_awsize),
        .m_AWVALID_i(m_awvalid),
        .m_AW_outst_full_i(m_full),
        .m_AWREADY_o(m_awready),
        .s_AWID_o(s_awid),
        .s_AWADDR_o(s_awaddr),
        .s_AWBURST_o(s_awburst),
        .s_AWLEN_o(s_awlen),
        .s_AWSIZE_o(s_awsize),
        .s_AWVALID_o(s_awvalid),
        .s_AWREADY_i(s_awready),
        .s_WVALID_i(s_wvalid),
        .s_WREADY_i(s_wready),
        .dsp_WDATA_mst_id_o(w_mst),
        .dsp_WDATA_disable_o(w_dis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] mv;
        logic [1:0] mf;
        logic       ar;
        logic       wv;
        logic       wr;
        logic       e_av;
        logic [1:0] e_ar;
        logic [5:0] e_id;
        logic       e_dis;
        logic       e_mid;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_awvalid = '0;
        m_full    = '0;
        s_awready = 1'b0;
        s_wvalid  = 1'b0;
        s_wready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        adv();
        adv();
        rst = 1'b0;
    endtask

    task automatic set_len(input logic [LW-1:0] l0, input logic [LW-1:0] l1);
        m_awlen = {l1, l0};
    endtask

    int hs;
    int gcnt;
    int gidx [4];
    int gcyc [4];
    int exp_g;

    initial begin
        rst       = 1'b1;
        m_awid    = {5'h15, 5'h0A};
        m_awaddr  = {32'h2000_0040, 32'h1000_0080};
        m_awburst = {2'b01, 2'b10};
        m_awsize  = {3'd2, 3'd3};
        set_len(3'd3, 3'd3);
        idle_inputs();

        //            mv     mf     ar wv wr  av  ar     id     dis mid
        tbl[0]  = '{2'b10, 2'b00, 1, 0, 0, 0, 2'b00, 6'h00, 1, 0};
        tbl[1]  = '{2'b10, 2'b00, 1, 0, 0, 1, 2'b10, 6'h35, 1, 0};
        tbl[2]  = '{2'b00, 2'b00, 0, 1, 1, 0, 2'b00, 6'h00, 0, 1};
        tbl[3]  = '{2'b00, 2'b00, 0, 1, 1, 0, 2'b00, 6'h00, 0, 1};
        tbl[4]  = '{2'b00, 2'b00, 0, 1, 1, 0, 2'b00, 6'h00, 0, 1};
        tbl[5]  = '{2'b00, 2'b00, 0, 1, 1, 0, 2'b00, 6'h00, 0, 1};
        tbl[6]  = '{2'b00, 2'b00, 0, 1, 1, 0, 2'b00, 6'h00, 1, 0};
        tbl[7]  = '{2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 6'h00, 1, 0};
        tbl[8]  = '{2'b11, 2'b01, 0, 0, 0, 0, 2'b00, 6'h00, 1, 0};
        tbl[9]  = '{2'b11, 2'b01, 0, 0, 0, 1, 2'b00, 6'h35, 1, 0};
        tbl[10] = '{2'b01, 2'b01, 1, 0, 0, 0, 2'b10, 6'h00, 1, 0};
        tbl[11] = '{2'b11, 2'b01, 1, 0, 0, 1, 2'b10, 6'h35, 1, 0};
        tbl[12] = '{2'b11, 2'b01, 0, 0, 0, 0, 2'b00, 6'h00, 0, 1};
        tbl[13] = '{2'b11, 2'b01, 1, 0, 0, 1, 2'b10, 6'h35, 0, 1};
        tbl[14] = '{2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 6'h00, 0, 1};

        do_reset();
        settle();
        check("rst_awvalid", 64'(s_awvalid), 64'd0);
        check("rst_awready", 64'(m_awready), 64'd0);
        check("rst_disable", 64'(w_dis), 64'd1);
        check("rst_mst_id", 64'(w_mst), 64'd0);
        adv();

        for (int i = 0; i < 15; i++) begin
            m_awvalid = tbl[i].mv;
            m_full    = tbl[i].mf;
            s_awready = tbl[i].ar;
            s_wvalid  = tbl[i].wv;
            s_wready  = tbl[i].wr;
            settle();
            check($sformatf("v%0d_awvalid", i), 64'(s_awvalid), 64'(tbl[i].e_av));
            check($sformatf("v%0d_awready", i), 64'(m_awready), 64'(tbl[i].e_ar));
            check($sformatf("v%0d_disable", i), 64'(w_dis), 64'(tbl[i].e_dis));
            check($sformatf("v%0d_mst_id", i), 64'(w_mst), 64'(tbl[i].e_mid));
            if (tbl[i].e_av) begin
                check($sformatf("v%0d_awid", i), 64'(s_awid), 64'(tbl[i].e_id));
                check($sformatf("v%0d_awaddr", i), 64'(s_awaddr), 64'h2000_0040);
                check($sformatf("v%0d_awlen", i), 64'(s_awlen), 64'd3);
            end
            adv();
        end

        // Arbitration order under continuous requests, single-beat bursts drained immediately
        do_reset();
        set_len(3'd0, 3'd0);
        m_awvalid = 2'b11;
        s_awready = 1'b1;
        s_wvalid  = 1'b1;
        s_wready  = 1'b1;
        gcnt = 0;
        for (int c = 0; c < 30 && gcnt < 4; c++) begin
            settle();
            if (s_awvalid && s_awready) begin
                gidx[gcnt] = int'(s_awid[IDW]);
                gcyc[gcnt] = c;
                gcnt++;
            end
            adv();
        end
        check("arb_grant_count", 64'(gcnt), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < gcnt) begin
`ifdef SA_WADDR_FIXED_PRIORITY_EN
                exp_g = 0;
`else
                exp_g = k % 2;
`endif
                check($sformatf("arb_grant%0d", k), 64'(gidx[k]), 64'(exp_g));
                if (k > 0) check($sformatf("arb_gap%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'd2);
            end
        end

        // Order FIFO full: two bursts accepted, third held until the first burst's last beat
        do_reset();
        set_len(3'd1, 3'd1);
        m_awvalid = 2'b11;
        s_awready = 1'b1;
        hs = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (s_awvalid && s_awready) hs++;
            adv();
        end
        check("full_hs_window1", 64'(hs), 64'd2);
        settle();
        check("full_disable", 64'(w_dis), 64'd0);
        check("full_head0", 64'(w_mst), 64'd0);
        adv();
        hs = 0;
        s_wvalid = 1'b1;
        s_wready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            if (s_awvalid && s_awready) hs++;
            adv();
        end
        check("full_hs_during_w", 64'(hs), 64'd0);
        s_wvalid = 1'b0;
        s_wready = 1'b0;
        settle();
        check("full_head_advanced", 64'(w_mst), 64'd1);
        hs = (s_awvalid && s_awready) ? 1 : 0;
        adv();
        for (int c = 0; c < 5; c++) begin
            settle();
            if (s_awvalid && s_awready) hs++;
            adv();
        end
        check("full_hs_window3", 64'(hs), 64'd1);

        // Reset while HOLD is waiting with a non-empty FIFO
        m_awvalid = 2'b10;
        s_awready = 1'b0;
        s_wvalid  = 1'b1;
        s_wready  = 1'b1;
        adv();
        adv();
        s_wvalid = 1'b0;
        s_wready = 1'b0;
        adv();
        adv();
        settle();
        check("hold_before_reset_awvalid", 64'(s_awvalid), 64'd1);
        check("hold_before_reset_disable", 64'(w_dis), 64'd0);
        adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        m_awvalid = 2'b11;
        settle();
        check("midrst_awvalid", 64'(s_awvalid), 64'd0);
        check("midrst_awready", 64'(m_awready), 64'd0);
        check("midrst_disable", 64'(w_dis), 64'd1);
        check("midrst_mst_id", 64'(w_mst), 64'd0);
        adv();
        settle();
        check("postrst_awvalid", 64'(s_awvalid), 64'd1);
        check("postrst_grant", 64'(s_awid), 64'h0A);
        adv();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
